// File: rtl/cla_arb_pkg.sv
// Shared types and widths for the time-shared CLA adder arbiter.
package cla_arb_pkg;
  localparam int HALF_W = 16;
  localparam int FULL_W = 32;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  typedef struct packed {
    logic [FULL_W-1:0] a;
    logic [FULL_W-1:0] b;
    logic              cin;
    logic              wide;
  } op_t;
endpackage

// File: rtl/CLA_16bit.sv
// 16-bit carry-lookahead adder: 4-bit lookahead groups plus a second lookahead level across groups.
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] p, g, c;
  logic [3:0]  gp, gg;
  logic [4:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;
    assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[k] = &p[B+3:B];
    assign c[B]   = gc[k];
    assign c[B+1] = g[B] | (p[B] & gc[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[k]);
  end

  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

// File: rtl/cla_adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cla_adder_arbiter.sv
// Round-robin time-sharing of one CLA_16bit among NUM_REQ requesters.
// Define CLA_ARB_WIDE_EN to enable 32-bit adds as two chained 16-bit passes.
module cla_adder_arbiter
  import cla_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FULL_W-1:0] req_a,
  input  logic [NUM_REQ*FULL_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  input  logic [NUM_REQ-1:0]        req_wide,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [FULL_W-1:0]         rsp_sum,
  output logic                      rsp_cout
);
  state_t state, state_nxt;
  op_t    op;
  logic [ID_W-1:0]   op_id, rr_ptr, ptr_nxt, gnt_id;
  logic [NUM_REQ-1:0] gnt;
  logic              gnt_any, wide_sel;
  logic [HALF_W-1:0] sum_lo, add_a, add_b, add_s;
  logic              c_mid, add_ci, add_co;
  logic [NUM_REQ-1:0][FULL_W-1:0] a_vec, b_vec;

  assign a_vec = req_a;
  assign b_vec = req_b;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .gnt(gnt), .gnt_id(gnt_id), .any(gnt_any)
  );

  CLA_16bit u_cla (.a(add_a), .b(add_b), .cin(add_ci), .sum(add_s), .cout(add_co));

  // A grant is only visible while idle and out of reset, so nothing latches during rst.
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign ptr_nxt   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = op_id;

`ifdef CLA_ARB_WIDE_EN
  logic [HALF_W-1:0] sum_hi;
  logic              cout;
  assign wide_sel = req_wide[gnt_id];
  assign rsp_sum  = op.wide ? {sum_hi, sum_lo} : {{HALF_W{1'b0}}, sum_lo};
  assign rsp_cout = op.wide ? cout : c_mid;
`else
  logic unused_bits;
  assign unused_bits = ^{req_wide, op.a[FULL_W-1:HALF_W], op.b[FULL_W-1:HALF_W], op.wide};
  assign wide_sel = 1'b0;
  assign rsp_sum  = {{HALF_W{1'b0}}, sum_lo};
  assign rsp_cout = c_mid;
`endif

  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    add_ci    = 1'b0;
    case (state)
      IDLE: if (gnt_any) state_nxt = LO;
      LO: begin
        add_a  = op.a[HALF_W-1:0];
        add_b  = op.b[HALF_W-1:0];
        add_ci = op.cin;
`ifdef CLA_ARB_WIDE_EN
        state_nxt = op.wide ? HI : RESP;
`else
        state_nxt = RESP;
`endif
      end
`ifdef CLA_ARB_WIDE_EN
      HI: begin
        add_a     = op.a[FULL_W-1:HALF_W];
        add_b     = op.b[FULL_W-1:HALF_W];
        add_ci    = c_mid;
        state_nxt = RESP;
      end
`endif
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      op     <= '0;
      op_id  <= '0;
      sum_lo <= '0;
      c_mid  <= 1'b0;
`ifdef CLA_ARB_WIDE_EN
      sum_hi <= '0;
      cout   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (gnt_any) begin
          op     <= '{a: a_vec[gnt_id], b: b_vec[gnt_id], cin: req_cin[gnt_id], wide: wide_sel};
          op_id  <= gnt_id;
          rr_ptr <= ptr_nxt;
        end
        LO: begin
          sum_lo <= add_s;
          c_mid  <= add_co;
        end
`ifdef CLA_ARB_WIDE_EN
        HI: begin
          sum_hi <= add_s;
          cout   <= add_co;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule
